done_event_logger: RTL and testbench
====================================

DONE_EVENT_LOGGER -- requirements
Module: done_event_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count; power of two, minimum 2.
REQ-002 SHALL have parameter TS_W, default 8, timestamp width in bits.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port g_in, input, 1, done flag from the upstream integrator control unit.
REQ-006 SHALL have port q_in, input, 4, upstream 4-bit counter value.
REQ-007 SHALL have port rd_ready, input, 1, consumer ready.
REQ-008 SHALL have port rd_valid, output, 1, head entry available.
REQ-009 SHALL have port rd_data, output, TS_W+4, head entry {timestamp, q}.
REQ-010 SHALL have port level, output, log2(DEPTH)+1, number of stored entries.
REQ-011 SHALL have port overflow, output, 1, sticky flag set when an event is dropped.
REQ-012 SHALL have port event_count, output, 8, saturating count of detected events, including dropped events.

Function
REQ-013 SHALL keep a free-running TS_W-bit timestamp counter:
- value 0 in the first cycle after clear_n deasserts;
- +1 every rising edge;
- wraps from 2^TS_W-1 to 0.
REQ-014 SHALL register g_in into g_prev each edge and define an event as g_in=1 while g_prev=0 at a rising edge (0->1 transition).
REQ-015 SHALL treat g_in held high for N cycles as one event; a new event requires g_in to return low for at least one sampled cycle.
REQ-016 On an event with the FIFO not full, SHALL write {timestamp value present before that edge, q_in sampled at that edge} into the tail slot at that edge.
REQ-017 SHALL make rd_valid = (level != 0), driven from registers; rd_data SHALL show the head entry combinationally (first-word fall-through).
REQ-018 SHALL raise rd_valid in the cycle following the edge at which an entry is written into an empty FIFO (one-cycle latency).
REQ-019 SHALL pop the head at a rising edge where rd_valid=1 and rd_ready=1; rd_ready with rd_valid=0 SHALL have no effect.
REQ-020 Push plus pop at the same edge SHALL leave level unchanged; both operations SHALL complete, including when level=DEPTH.
REQ-021 An event at level=DEPTH with no pop SHALL be dropped: no write, level unchanged, overflow set to 1.
REQ-022 overflow SHALL stay 1 until clear_n asserts.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or drop below 0.
REQ-024 event_count SHALL increment once per detected event and saturate at 255.
REQ-025 rd_data SHALL hold stable while rd_valid=1 and rd_ready=0.

Reset
REQ-026 clear_n=0 SHALL immediately, without waiting for a clock edge, force:
- timestamp=0, g_prev=0, pointers=0, level=0;
- rd_valid=0, overflow=0, event_count=0.
REQ-027 Reset asserted mid-operation SHALL discard all stored entries; rd_data content under reset is don't-care.
REQ-028 A g_in already high at reset release SHALL count as an event at the first edge, because g_prev resets to 0.

Verification
REQ-029 Reset release, g_in rises at the edge where timestamp=5, q_in=4'hF, rd_ready=0 -> next cycle rd_valid=1, rd_data={8'd5,4'hF}, level=1, event_count=1.
REQ-030 g_in held high 10 cycles -> exactly one entry, event_count=1.
REQ-031 Five separated events, rd_ready=0, DEPTH=4 -> level=4, fifth dropped, overflow=1, event_count=5; draining then returns the first four entries in order.
REQ-032 Full FIFO, event and rd_ready=1 on the same edge -> level stays 4, new entry is at the tail, overflow stays 0.
REQ-033 Timestamp wrap: event at timestamp 255, then event 2 cycles later -> stored timestamps 255 then 1.
REQ-034 clear_n pulsed low asynchronously with level=3 -> level=0, rd_valid=0, overflow=0 before the next clock edge.

Source files
------------

// File: rtl/done_event_logger.sv
// Logs rising edges of an upstream done flag as {timestamp, q} entries
// in a small first-word fall-through FIFO with sticky overflow.
module done_event_logger #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic                       clock,
    input  logic                       clear_n,
    input  logic                       g_in,
    input  logic [3:0]                 q_in,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [TS_W+3:0]            rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [7:0]                 event_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [TS_W-1:0] r_ts;
    logic            r_g_prev;
    logic [TS_W+3:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_level;
    logic            r_ovf;
    logic [7:0]      r_evcnt;

    logic w_event;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_event = g_in & ~r_g_prev;
    assign w_full  = (r_level == LVL_FULL);
    assign w_pop   = (r_level != '0) & rd_ready;
    // A pop at the same edge frees the slot, so a full FIFO still accepts.
    assign w_push  = w_event & (~w_full | w_pop);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_ts     <= '0;
            r_g_prev <= 1'b0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
            r_evcnt  <= '0;
        end else begin
            r_ts     <= r_ts + 1'b1;
            r_g_prev <= g_in;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop) r_level <= r_level + 1'b1;
            else if (!w_push && w_pop) r_level <= r_level - 1'b1;
            if (w_event && !w_push) r_ovf <= 1'b1;
            if (w_event && r_evcnt != 8'hFF) r_evcnt <= r_evcnt + 1'b1;
        end
    end

    // Storage needs no reset; emptiness is tracked by r_level.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= {r_ts, q_in};
    end

    assign rd_valid    = (r_level != '0);
    assign rd_data     = r_mem[r_rptr];
    assign level       = r_level;
    assign overflow    = r_ovf;
    assign event_count = r_evcnt;

endmodule

// File: tb/tb_done_event_logger.sv
// Scoreboard bench for done_event_logger: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_done_event_logger;

    localparam int DEPTH = 4;
    localparam int TS_W  = 8;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        g_in;
    logic [3:0]  q_in;
    logic        rd_ready;
    logic        rd_valid;
    logic [11:0] rd_data;
    logic [2:0]  level;
    logic        overflow;
    logic [7:0]  event_count;

    int tests = 0;
    int fails = 0;

    done_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clock(clock), .clear_n(clear_n), .g_in(g_in), .q_in(q_in),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .level(level), .overflow(overflow), .event_count(event_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected FIFO contents and counters.
    logic [11:0] sb[$];
    int m_ts = 0;
    bit m_gprev = 0;
    int m_level = 0;
    bit m_ovf = 0;
    int m_cnt = 0;

    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            m_ts = 0; m_gprev = 0; m_level = 0; m_ovf = 0; m_cnt = 0;
            sb.delete();
        end else begin
            bit ev, pop;
            logic [7:0] ts8;
            ev  = g_in && !m_gprev;
            pop = (m_level > 0) && rd_ready;
            ts8 = m_ts[7:0];
            if (ev) begin
                if (m_cnt < 255) m_cnt = m_cnt + 1;
                if (m_level < DEPTH || pop) begin
                    sb.push_back({ts8, q_in});
                    m_level = m_level + 1;
                end else begin
                    m_ovf = 1;
                end
            end
            if (pop) m_level = m_level - 1;
            m_gprev = g_in;
            m_ts = (m_ts + 1) % 256;
        end
    end

    // Monitor: compares status each cycle and the head on every transfer.
    always @(negedge clock) begin
        chk("level", 32'(level), 32'(m_level));
        chk("rd_valid", 32'(rd_valid), 32'(m_level != 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("event_count", 32'(event_count), 32'(m_cnt));
        if (rd_valid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                chk("rd_data", 32'(rd_data), 32'(sb[0]));
                if (rd_ready && clear_n) void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        repeat (2) step();
        clear_n = 1'b1;
    endtask

    initial begin
        clear_n = 1'b0; g_in = 1'b0; q_in = 4'h0; rd_ready = 1'b0;
        repeat (3) step();
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_valid", 32'(rd_valid), 32'd0);
        clear_n = 1'b1;

        // First event at timestamp 5, then held high 10 cycles total.
        repeat (5) step();
        g_in = 1'b1; q_in = 4'hF;
        step();
        @(negedge clock);
        chk("first_valid", 32'(rd_valid), 32'd1);
        chk("first_data", 32'(rd_data), 32'h05F);
        repeat (9) step();
        g_in = 1'b0;
        step();
        @(negedge clock);
        chk("held_count", 32'(event_count), 32'd1);
        chk("held_level", 32'(level), 32'd1);

        // Four more events: fifth overall is dropped.
        for (int i = 0; i < 4; i++) begin
            g_in = 1'b1; q_in = 4'(i + 1);
            step();
            g_in = 1'b0;
            step();
        end
        @(negedge clock);
        chk("full_level", 32'(level), 32'd4);
        chk("full_ovf", 32'(overflow), 32'd1);
        chk("full_count", 32'(event_count), 32'd5);
        rd_ready = 1'b1;
        repeat (5) step();
        rd_ready = 1'b0;
        @(negedge clock);
        chk("drained", 32'(level), 32'd0);

        // Async reset with three entries stored.
        for (int i = 0; i < 3; i++) begin
            g_in = 1'b1; q_in = 4'(i + 8);
            step();
            g_in = 1'b0;
            step();
        end
        @(posedge clock);
        #2 clear_n = 1'b0;
        #1;
        chk("async_level", 32'(level), 32'd0);
        chk("async_valid", 32'(rd_valid), 32'd0);
        chk("async_ovf", 32'(overflow), 32'd0);
        chk("async_count", 32'(event_count), 32'd0);
        step();
        clear_n = 1'b1;

        // Full FIFO: push and pop at the same edge.
        for (int i = 0; i < 4; i++) begin
            g_in = 1'b1; q_in = 4'(i + 3);
            step();
            g_in = 1'b0;
            step();
        end
        g_in = 1'b1; q_in = 4'hA; rd_ready = 1'b1;
        step();
        g_in = 1'b0; rd_ready = 1'b0;
        @(negedge clock);
        chk("pp_level", 32'(level), 32'd4);
        chk("pp_ovf", 32'(overflow), 32'd0);
        rd_ready = 1'b1;
        repeat (4) step();
        rd_ready = 1'b0;

        // Timestamp wrap: events at 255 and at 1.
        @(posedge clock);
        #2 clear_n = 1'b0;
        step();
        clear_n = 1'b1;
        repeat (255) step();
        g_in = 1'b1; q_in = 4'h3;
        step();
        g_in = 1'b0;
        step();
        g_in = 1'b1; q_in = 4'h4;
        step();
        g_in = 1'b0;
        @(negedge clock);
        chk("wrap_head", 32'(rd_data), 32'hFF3);
        chk("wrap_level", 32'(level), 32'd2);
        rd_ready = 1'b1;
        step();
        @(negedge clock);
        chk("wrap_second", 32'(rd_data), 32'h014);
        step();

        // Randomized traffic; long enough to saturate event_count.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            g_in = 1'($urandom_range(0, 1));
            q_in = 4'($urandom_range(0, 15));
            rd_ready = ($urandom_range(0, 9) < 4);
            step();
        end
        g_in = 1'b0; rd_ready = 1'b1;
        repeat (6) step();
        @(negedge clock);
        chk("end_empty", 32'(level), 32'd0);
        chk("end_sat", 32'(event_count), 32'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
